// File: rtl/serial_addsub.sv
// Bit-serial two's-complement add/subtract: one full-adder cell plus a carry flop,
// LSB-first over WIDTH cycles, with valid/ready handshakes on both sides.
module serial_addsub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_xs;
  logic [WIDTH-1:0] r_ys;
  logic [WIDTH-1:0] r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_c;
  logic             r_op;
  logic             r_carry;
  logic             r_ovf;
  logic             r_zero;
  logic             r_out_valid;
  logic             r_in_ready;
  logic             r_busy;

  logic             w_sum;
  logic             w_c_next;
  logic [WIDTH-1:0] w_res_next;

  // Single full-adder cell on the operand LSBs
  assign w_sum      = r_xs[0] ^ r_ys[0] ^ r_c;
  assign w_c_next   = (r_xs[0] & r_ys[0]) | (r_xs[0] & r_c) | (r_ys[0] & r_c);
  assign w_res_next = {w_sum, r_result[WIDTH-1:1]};

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign carry_out = r_carry;
  assign overflow  = r_ovf;
  assign zero      = r_zero;
  assign busy      = r_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_xs        <= '0;
      r_ys        <= '0;
      r_result    <= '0;
      r_cnt       <= '0;
      r_c         <= 1'b0;
      r_op        <= 1'b0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Subtraction is x + ~y + 1: invert y here, inject the +1 as carry-in
          if (in_valid && r_in_ready) begin
            r_xs       <= x;
            r_ys       <= y ^ {WIDTH{op}};
            r_op       <= op;
            r_c        <= op;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_c      <= w_c_next;
          r_xs     <= r_xs >> 1;
          r_ys     <= r_ys >> 1;
          r_result <= w_res_next;
          r_cnt    <= r_cnt + CNT_W'(1);
          // MSB cell: r_c is the carry into it, w_c_next the carry out of it
          if (r_cnt == LAST_BIT) begin
            r_carry     <= w_c_next ^ r_op;
            r_ovf       <= w_c_next ^ r_c;
            r_zero      <= (w_res_next == '0);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: accepted pairs are modelled with plain
// integer arithmetic and popped by an independent output monitor.
module tb_serial_addsub;

  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
    int           cyc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;
  logic         busy;

  exp_t sb[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   acc_last = 0;
  bit   seen = 0;
  bit   stray = 0;
  bit   rand_rdy = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .overflow(overflow),
    .zero(zero), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic, no bit-level adder
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic o);
    exp_t   e;
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = longint'($signed(a));
    longint sbv = longint'($signed(b));
    longint smax = (longint'(1) <<< (W - 1)) - 1;
    longint smin = -(longint'(1) <<< (W - 1));
    longint r;
    longint s;
    if (o) begin
      r   = ua - ub;
      s   = sa - sbv;
      e.c = (ua < ub);
    end else begin
      r   = ua + ub;
      s   = sa + sbv;
      e.c = (r >= (longint'(1) <<< W));
    end
    e.res = r[W-1:0];
    e.v   = (s > smax) || (s < smin);
    e.z   = (e.res == '0);
    e.cyc = 0;
    return e;
  endfunction

  // Handshake observer: pushes the expectation at the accepting edge
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      sb.delete();
    end else if (in_valid && in_ready) begin
      e     = model(x, y, op);
      e.cyc = cyc;
      sb.push_back(e);
      acc_cnt++;
      acc_last = cyc;
    end
  end

  // Output monitor
  always @(negedge clk) begin
    if (out_valid) begin
      chk("busy_in_done", 32'(busy), 32'd1);
      chk("in_ready_in_done", 32'(in_ready), 32'd0);
      if (!seen) begin
        seen = 1;
        if (sb.size() == 0) begin
          stray = 1;
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out_valid: got result 0x%0h expected no output", result);
        end else begin
          stray = 0;
          cur = sb.pop_front();
          chk("result", 32'(result), 32'(cur.res));
          chk("carry_out", 32'(carry_out), 32'(cur.c));
          chk("overflow", 32'(overflow), 32'(cur.v));
          chk("zero", 32'(zero), 32'(cur.z));
          chk("latency", 32'(cyc - cur.cyc), 32'(W));
        end
      end else if (!stray) begin
        chk("hold_result", 32'(result), 32'(cur.res));
        chk("hold_flags", 32'({carry_out, overflow, zero}), 32'({cur.c, cur.v, cur.z}));
      end
    end else begin
      seen = 0;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic o, input bit keep);
    int start = acc_cnt;
    int n = 0;
    x = a;
    y = b;
    op = o;
    in_valid = 1'b1;
    while (acc_cnt == start && n < 200) begin
      @(negedge clk);
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    if (acc_cnt == start) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
    end
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(negedge clk);
  endtask

  initial begin
    int t1, t2, t3, n;
    logic [W-1:0] edge_v[4];
    logic [W-1:0] ra, rb;
    edge_v[0] = 16'h0000; edge_v[1] = 16'h8000; edge_v[2] = 16'hFFFF; edge_v[3] = 16'h7FFF;

    rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; op = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outputs", 32'({result, carry_out, overflow, zero, busy}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed arithmetic cases
    send(16'h0005, 16'h0003, 1'b1, 0); drain();
    send(16'h0003, 16'h0005, 1'b1, 0); drain();
    send(16'h8000, 16'h0001, 1'b1, 0); drain();
    send(16'h7FFF, 16'h0001, 1'b0, 0); drain();
    send(16'hFFFF, 16'h0001, 1'b0, 0); drain();
    send(16'h0000, 16'h0000, 1'b1, 0); drain();
    send(16'hFFFF, 16'hFFFF, 1'b0, 0); drain();

    // Backpressure in DONE, with an ignored in_valid pulse
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 0);
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk("bp_reached_done", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin x = 16'h1234; y = 16'h0001; in_valid = 1'b1; end
      if (i == 2) in_valid = 1'b0;
      @(negedge clk);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_still_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_released", 32'(out_valid), 32'd0);
    chk("bp_in_ready_rise", 32'(in_ready), 32'd1);
    drain();

    // Reset while counter == 7
    send(16'hAAAA, 16'h1111, 1'b0, 0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_outputs", 32'({result, carry_out, overflow, zero, busy}), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    repeat (20) @(negedge clk);
    send(16'h0010, 16'h0020, 1'b0, 0); drain();

    // Back-to-back with in_valid held high
    send(16'h0101, 16'h0202, 1'b0, 1); t1 = acc_last;
    send(16'h0300, 16'h0400, 1'b1, 1); t2 = acc_last;
    send(16'hF000, 16'h1000, 1'b0, 0); t3 = acc_last;
    chk("b2b_spacing_1", 32'(t2 - t1), 32'(W + 2));
    chk("b2b_spacing_2", 32'(t3 - t2), 32'(W + 2));
    drain();

    // Randomised traffic with random backpressure
    rand_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : W'($urandom);
      send(ra, rb, 1'($urandom_range(0, 1)), 0);
    end
    rand_rdy = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial two's-complement add/subtract unit with valid/ready handshakes on both sides.
- Sits directly upstream of the 16-bit result/flag consumers. It is the area-reduced alternative feeder to the parallel ripple subtractor.
- Processes one operand pair per transaction, LSB-first, using a single full-adder cell and a carry flop over WIDTH cycles.
- Produces the same outputs as the parallel unit: result, carry/borrow, signed overflow, plus a zero flag.

Parameters:
- WIDTH, 16, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), width of the internal bit counter (derived, not overridden).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  upstream presents x, y, op.
- in_ready  output  1  unit can accept an operand pair.
- x  input  WIDTH  minuend / first addend.
- y  input  WIDTH  subtrahend / second addend.
- op  input  1  0 = x+y, 1 = x-y.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  downstream accepts the result.
- result  output  WIDTH  sum or difference, modulo 2^WIDTH.
- carry_out  output  1  add: carry out of MSB; sub: borrow (C_msb XOR op).
- overflow  output  1  signed overflow, C_msb XOR C_msb-1.
- zero  output  1  result == 0.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low at an edge):
  - State goes to IDLE.
  - result, carry_out, overflow, zero, out_valid all go to 0; busy = 0.
  - Internal operand shift registers, counter and carry flop are cleared.
  - Reset wins over every other event, including a mid-RUN transaction; that transaction is discarded with no output.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid & in_ready:
    - Load x into shift register xs.
    - Load (y XOR {WIDTH{op}}) into ys.
    - Latch op.
    - Carry flop c <= op; counter <= 0.
    - Go to RUN.
- RUN:
  - in_ready = 0; in_valid is ignored.
  - Each edge:
    - s = xs[0]^ys[0]^c.
    - c <= majority(xs[0], ys[0], c).
    - xs and ys shift right by 1.
    - s is shifted into result at bit WIDTH-1 (result shifts right).
    - Previous c is saved as c_prev.
    - counter increments.
  - On the edge where counter == WIDTH-1:
    - Final bit is written.
    - carry_out <= new_c ^ op.
    - overflow <= new_c ^ c_in_of_msb (the carry into the MSB cell, i.e. c before this edge).
    - Go to DONE.
  - result may show partial values during RUN; consumers must only sample when out_valid = 1.
- DONE:
  - out_valid = 1.
  - zero = (result == 0), held registered.
  - result and all flags are held stable while out_valid & !out_ready (backpressure of any length).
  - On an edge with out_ready = 1: out_valid <= 0 and go to IDLE. in_ready rises the following cycle; DONE->IDLE and accept do not overlap.
- Latency and throughput:
  - Input accepted at edge T; out_valid is first high after edge T+WIDTH.
  - Maximum throughput is one transaction per WIDTH+2 cycles.
- Arithmetic:
  - Equivalent to parallel x + (y XOR op) + op.
  - Examples: 0x0000-0x0000 gives carry_out = 0; 0xFFFF+0xFFFF gives 0xFFFE with carry_out = 1.
- Flags stay registered in IDLE until the next transaction completes. out_valid alone qualifies them.
- Inputs x, y, op may change freely after acceptance.

Test Plan:
- WIDTH = 16, op = 1, x = 0x0005, y = 0x0003 accepted at edge T -> out_valid after edge T+16; result = 0x0002, carry_out = 0, overflow = 0, zero = 0.
- op = 1, x = 0x0003, y = 0x0005 -> result = 0xFFFE, carry_out = 1 (borrow), overflow = 0. Then op = 1, x = 0x8000, y = 0x0001 -> result = 0x7FFF, overflow = 1, carry_out = 0.
- op = 0, x = 0x7FFF, y = 0x0001 -> result = 0x8000, overflow = 1, carry_out = 0. Then x = 0xFFFF, y = 0x0001 -> result = 0x0000, carry_out = 1, zero = 1, overflow = 0.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE -> result and flags unchanged, in_ready = 0. A new in_valid pulse with x = 0x1234 is ignored. After out_ready = 1, in_ready rises one cycle later.
- Reset mid-run: rst_n = 0 for one edge at counter = 7 -> all outputs 0, state IDLE, in_ready = 1, no out_valid for the aborted pair. Next pair 0x0010+0x0020 -> 0x0030.
- Back-to-back: in_valid held high with three pairs, out_ready = 1 -> accepts spaced exactly WIDTH+2 cycles apart; results in order.
